// File: rtl/dmem_arb_pkg.sv
// Shared types and sizing helpers for the data-memory arbiter.
package dmem_arb_pkg;

    // Access sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    // Requester identity, used for the winner latch and the tie-break pointer.
    typedef enum logic {
        REQ_CORE = 1'b0,
        REQ_DBG  = 1'b1
    } req_id_t;

    // Largest supported read latency and the counter width it needs.
    localparam int RD_LAT_MAX = 3;
    localparam int CNT_W_MAX  = $clog2(RD_LAT_MAX + 1);

    // Latency counter width for a given read latency.
    function automatic int cnt_width(input int rd_lat);
        return $clog2(rd_lat + 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester always wins; on a tie the
// requester that was not granted last wins. Purely combinational.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       req_core_i,
    input  logic       req_dbg_i,
    input  logic       last_gnt_i,   // REQ_CORE / REQ_DBG encoding
    output logic [1:0] gnt_o         // bit 0 = core, bit 1 = debug
);

    // One-hot grant selection.
    always_comb begin
        gnt_o = 2'b00;
        if (req_core_i && req_dbg_i) begin
            gnt_o = (last_gnt_i == REQ_CORE) ? 2'b10 : 2'b01;
        end else if (req_core_i) begin
            gnt_o = 2'b01;
        end else if (req_dbg_i) begin
            gnt_o = 2'b10;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the core load/store path and the
// debug/loader port. Each granted access runs IDLE -> ACCESS -> ACK; all
// memory-side controls, acks and read data are registered.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              c_req,
    input  logic              c_wr,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [DATA_W-1:0] c_wdata,
    output logic              c_ack,
    output logic [DATA_W-1:0] c_rdata,
    output logic              c_stall,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int              CNT_W     = cnt_width(RD_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_RDLAT = CNT_W'(RD_LAT);

    state_t              state_q;
    req_id_t             prio_q;      // requester that wins the next tie
    req_id_t             owner_q;     // requester of the access in flight
    logic                rd_q;        // access in flight is a read
    logic [CNT_W-1:0]    cnt_q;
    logic                mem_wr_q;
    logic                mem_rd_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                c_ack_q;
    logic                d_ack_q;
    logic [DATA_W-1:0]   c_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;

    logic                last_gnt_d;
    logic [1:0]          gnt_d;
    logic                win_dbg_d;
    logic                sel_wr_d;
    logic [ADDR_W-1:0]   sel_addr_d;
    logic [DATA_W-1:0]   sel_wdata_d;

    // The arbiter expects the last-granted id; that is the opposite of
    // whoever currently holds tie priority.
    assign last_gnt_d = (prio_q == REQ_CORE) ? REQ_DBG : REQ_CORE;

    rr_arb2 u_rr_arb2 (
        .req_core_i (c_req),
        .req_dbg_i  (d_req),
        .last_gnt_i (last_gnt_d),
        .gnt_o      (gnt_d)
    );

    // Route the winning requester's fields toward the memory-side latches.
    always_comb begin
        win_dbg_d   = gnt_d[1];
        sel_wr_d    = c_wr;
        sel_addr_d  = c_addr;
        sel_wdata_d = c_wdata;
        if (gnt_d[1]) begin
            sel_wr_d    = d_wr;
            sel_addr_d  = d_addr;
            sel_wdata_d = d_wdata;
        end
    end

    // Access sequencer: grant in IDLE, count latency in ACCESS, pulse ack in ACK.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            prio_q      <= REQ_CORE;
            owner_q     <= REQ_CORE;
            rd_q        <= 1'b0;
            cnt_q       <= '0;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            c_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            c_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            mem_wr_q <= 1'b0;
            mem_rd_q <= 1'b0;
            c_ack_q  <= 1'b0;
            d_ack_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_d != 2'b00) begin
                        owner_q     <= win_dbg_d ? REQ_DBG : REQ_CORE;
                        prio_q      <= win_dbg_d ? REQ_CORE : REQ_DBG;
                        rd_q        <= !sel_wr_d;
                        mem_wr_q    <= sel_wr_d;
                        mem_rd_q    <= !sel_wr_d;
                        mem_addr_q  <= sel_addr_d;
                        mem_wdata_q <= sel_wdata_d;
                        cnt_q       <= sel_wr_d ? CNT_ONE : CNT_RDLAT;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_q == CNT_ONE) begin
                        if (rd_q) begin
                            if (owner_q == REQ_DBG) begin
                                d_rdata_q <= mem_rdata;
                            end else begin
                                c_rdata_q <= mem_rdata;
                            end
                        end
                        if (owner_q == REQ_DBG) begin
                            d_ack_q <= 1'b1;
                        end else begin
                            c_ack_q <= 1'b1;
                        end
                        state_q <= ACK;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ACK: begin
                    // No arbitration here, so a requester dropping req on the
                    // ack edge cannot be granted again.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_wr    = mem_wr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign c_ack     = c_ack_q;
    assign d_ack     = d_ack_q;
    assign c_rdata   = c_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign c_stall   = c_req && !c_ack_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the core load/store path and a debug/loader port used for program and data preload and inspection.
- Arbitrates round-robin and sequences each access through a small FSM.
- Registers all memory-side controls.
- Returns a one-cycle acknowledge, plus read data for reads, to the winning requester.
- Sits between the datapath's memory interface and the data memory instance.

Parameters:
- DATA_W, 32, data width of all data buses.
- ADDR_W, 9, memory word/byte address width (matches the data memory's address port).
- RD_LAT, 1, cycles from the first cycle of mem_rd high to mem_rdata valid; legal values 1..3.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- c_req  in  1  core access request; held with its fields until c_ack
- c_wr  in  1  core access type: 1 = write, 0 = read
- c_addr  in  ADDR_W  core address
- c_wdata  in  DATA_W  core write data
- c_ack  out  1  one-cycle completion pulse to core
- c_rdata  out  DATA_W  core read data; valid with c_ack; held until the next core read completes
- c_stall  out  1  c_req && !c_ack; the pipeline freezes on this
- d_req, d_wr, d_addr, d_wdata  in  1/1/ADDR_W/DATA_W  debug-side equivalents of the core inputs
- d_ack  out  1  debug completion pulse
- d_rdata  out  DATA_W  debug read data (same rules as c_rdata)
- mem_wr  out  1  memory write enable (registered)
- mem_rd  out  1  memory read enable (registered)
- mem_addr  out  ADDR_W  memory address (registered)
- mem_wdata  out  DATA_W  memory write data (registered)
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; priority pointer = core; latency counter 0.
- A reset mid-access aborts the access: no ack is issued, and mem_wr/mem_rd are low the cycle after reset is sampled.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - No request: stay IDLE.
  - Exactly one request: grant it.
  - Both requesting: grant the requester not granted last; after reset the core wins the first tie.
  - On grant: latch winner id, wr, addr and wdata into mem_addr/mem_wdata; set mem_wr = wr, mem_rd = !wr; load counter = RD_LAT for reads, 1 for writes; update the priority pointer; go to ACCESS.
- ACCESS:
  - mem_rd is high only in the first ACCESS cycle; mem_wr is high only in the first ACCESS cycle.
  - mem_addr and mem_wdata are held for the whole of ACCESS.
  - Counter decrements each cycle.
  - When counter == 1: for a read, capture mem_rdata into the winner's rdata register; assert the winner's ack (registered) and go to ACK.
- ACK:
  - The ack is high for exactly this one cycle; no arbitration occurs.
  - Clear mem_addr/mem_wdata are not required; hold their values.
  - Next state IDLE. This guarantees a requester dropping req on the ack edge is never re-granted.
- Latency (request first seen in IDLE at cycle 0): write ack in cycle 2; read ack in cycle RD_LAT+1. Throughput is one access per 3 (write) or RD_LAT+2 (read) cycles.
- Request changes while not granted are legal. A requester must not change fields between grant and ack; fields are latched, so later changes are ignored.
- The non-granted rdata register is untouched by the other requester's accesses.
- c_stall is combinational from c_req and c_ack. It is high during any debug access while the core requests.
- Widths: no arithmetic on data; the counter is $clog2(RD_LAT+1) bits and never wraps below 1.

Decomposition:
- Package dmem_arb_pkg: state enum (IDLE, ACCESS, ACK); requester id enum (REQ_CORE, REQ_DBG); localparam for counter width.
- One sub-module: rr_arb2, a 2-way round-robin pick. Inputs: two reqs and the last-grant pointer. Outputs: one-hot grant. Purely combinational.

Test Plan:
- Reset, then core write c_addr=0x010, c_wdata=0xDEADBEEF, RD_LAT=1 -> mem_wr=1 in cycle 1 only, mem_addr=0x010; c_ack in cycle 2; c_stall high cycles 0-1.
- Core read of 0x010 with the memory model returning 0xDEADBEEF -> mem_rd high cycle 1; c_ack cycle 2 with c_rdata=0xDEADBEEF; d_rdata unchanged (0).
- c_req and d_req both raised the cycle after reset, held -> core granted first (c_ack cycle 2), debug next (mem access cycle 4, d_ack cycle 5); repeated ties alternate strictly.
- RD_LAT=3, debug read of 0x1FF returning 0x12345678 -> mem_rd high one cycle; d_ack in cycle 4; d_rdata=0x12345678.
- Reset asserted in the ACCESS cycle of a core write -> no c_ack; mem_wr=0 the next cycle; the next tie goes to the core.
- Debug continuous back-to-back reads while core idle -> one access per RD_LAT+2 cycles; a core request raised mid-stream is served right after the in-flight debug access.
